// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry process the
// operands LSB first, one bit per clock, behind a valid/ready handshake on
// both the operand side and the result side.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
);

    // Counter is wide enough to hold WIDTH itself, so it never wraps.
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    count;
    logic             sum_bit;
    logic             carry_next;

    // The single full-adder cell working on the current LSBs and stored carry.
    always_comb begin
        sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    end

    // The result shift register and the carry register are the outputs, so
    // the last completed sum stays visible through DONE and the following IDLE.
    // in_ready is gated by rst_n so it drops the moment reset is asserted.
    assign in_ready = (state == IDLE) && rst_n;
    assign s        = res_sh;
    assign cout     = carry;

    // Control FSM and datapath: capture on accept, shift one bit per RUN
    // cycle, then hold the result in DONE until it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_sh <= {sum_bit, res_sh[WIDTH-1:1]};
                    carry  <= carry_next;
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes the expected result and
// accept time into queues, an independent monitor pops and compares them.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [WIDTH:0]   sb[$];
    int               accQ[$];
    logic             prevOv = 1'b0;
    logic [WIDTH-1:0] heldS  = '0;
    logic             heldC  = 1'b0;
    logic [WIDTH:0]   expv;
    bit               randomReady = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Edge counter used to measure accept-to-result latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer back-pressure, applied just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Monitor: latency on each rising out_valid, hold-stability while valid,
    // and result comparison on every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prevOv) begin
                checkOutput("result_has_accept", 32'(accQ.size() != 0), 1);
                if (accQ.size() != 0) checkOutput("latency", cyc - accQ.pop_front(), WIDTH);
                heldS = s;
                heldC = cout;
            end else if (out_valid && prevOv) begin
                checkOutput("hold_s", 32'(s), 32'(heldS));
                checkOutput("hold_cout", 32'(cout), 32'(heldC));
            end
            if (out_valid && out_ready) begin
                checkOutput("result_pending", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    expv = sb.pop_front();
                    checkOutput("sum", 32'(s), 32'(expv[WIDTH-1:0]));
                    checkOutput("cout", 32'(cout), 32'(expv[WIDTH]));
                end
            end
            prevOv = out_valid;
        end else begin
            prevOv = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic [WIDTH:0] expected);
        int waitCycles = 0;
        @(posedge clk);
        #1;
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("accept_seen", 32'(in_ready), 1);
        if (in_ready) begin
            sb.push_back(expected);
            accQ.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOutValid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("out_valid_seen", 32'(out_valid), 1);
    endtask

    task automatic waitDrain();
        int n = 0;
        @(negedge clk);
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sb.size(), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;

        // Reset state while rst_n is held low
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 0);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_s", 32'(s), 0);
        checkOutput("reset_cout", 32'(cout), 0);
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 1);

        // Directed sums
        out_ready = 1'b1;
        applyStimulus(8'h5A, 8'h33, 1'b0, 9'h08D);
        waitDrain();
        applyStimulus(8'hFF, 8'h01, 1'b0, 9'h100);
        waitDrain();
        applyStimulus(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        waitDrain();

        // Hold the result in DONE while wiggling the operand side
        out_ready = 1'b0;
        applyStimulus(8'hC3, 8'h3C, 1'b1, 9'h100);
        waitOutValid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            a        = 8'($urandom);
            b        = 8'($urandom);
            cin      = ~cin;
            @(negedge clk);
            checkOutput("done_out_valid", 32'(out_valid), 1);
            checkOutput("done_s", 32'(s), 32'h00);
            checkOutput("done_cout", 32'(cout), 1);
            checkOutput("done_in_ready", 32'(in_ready), 0);
            checkOutput("done_busy", 32'(busy), 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("idle_out_valid", 32'(out_valid), 0);
        checkOutput("idle_in_ready", 32'(in_ready), 1);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_s_kept", 32'(s), 32'h00);
        checkOutput("idle_cout_kept", 32'(cout), 1);
        checkOutput("hold_drain", sb.size(), 0);

        // Asynchronous reset three cycles into RUN
        out_ready = 1'b1;
        applyStimulus(8'h12, 8'h34, 1'b0, 9'h046);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_s", 32'(s), 0);
        checkOutput("midrun_reset_cout", 32'(cout), 0);
        checkOutput("midrun_reset_out_valid", 32'(out_valid), 0);
        checkOutput("midrun_reset_busy", 32'(busy), 0);
        checkOutput("midrun_reset_in_ready", 32'(in_ready), 0);
        sb.delete();
        accQ.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rerelease_in_ready", 32'(in_ready), 1);
        applyStimulus(8'h10, 8'h20, 1'b1, 9'h031);
        waitDrain();

        // Random traffic with stalls on both sides
        randomReady = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc));
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        randomReady = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain();
        checkOutput("accept_queue_empty", accQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
